// File: rtl/mpmix_pkg.sv
// ============================================================================
// mpmix_pkg -- shared sample type, saturation limits and 24-bit saturator
// Revision: 1.0
// ============================================================================
`default_nettype none

package mpmix_pkg;

  localparam int          SAMPLE_W = 24;
  localparam logic [23:0] SAT_MAX  = 24'h7FFFFF;
  localparam logic [23:0] SAT_MIN  = 24'h800000;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t value;
    logic    clipped;
  } sat_t;

  function automatic sat_t sat24(input logic signed [31:0] acc);
    sat_t r;
    if (acc > 32'sd8388607) begin
      r.value   = SAT_MAX;
      r.clipped = 1'b1;
    end else if (acc < -32'sd8388608) begin
      r.value   = SAT_MIN;
      r.clipped = 1'b1;
    end else begin
      r.value   = acc[SAMPLE_W-1:0];
      r.clipped = 1'b0;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mpmix_tagdly.sv
// ============================================================================
// mpmix_tagdly -- DEPTH-stage {valid,last} delay line aligned to the multiplier
// Revision: 1.0
// ============================================================================
`default_nettype none

module mpmix_tagdly #(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  input  logic last_i,
  output logic valid_o,
  output logic last_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] last_q;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= '0;
          last_q  <= '0;
        end else begin
          valid_q <= valid_i;
          last_q  <= last_i & valid_i;
        end
      end
    end else begin : g_chain
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= '0;
          last_q  <= '0;
        end else begin
          valid_q <= {valid_q[DEPTH-2:0], valid_i};
          last_q  <= {last_q[DEPTH-2:0], last_i & valid_i};
        end
      end
    end
  endgenerate

  assign valid_o = valid_q[DEPTH-1];
  assign last_o  = last_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/mpmix_accum.sv
// ============================================================================
// mpmix_accum -- sums per-channel products into one saturated frame sample
// Optional clip counter: define MPMIX_CLIP_CNT_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module mpmix_accum
  import mpmix_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int MP_LATENCY = 5,
  parameter int ACC_W      = 28
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ch_valid_i,
  input  logic                ch_last_i,
  input  logic signed [23:0]  mprod_i,
  output logic signed [23:0]  mix_o,
  output logic                mix_valid_o,
  input  logic                mix_ack_i,
  output logic                overrun_o
`ifdef MPMIX_CLIP_CNT_EN
  ,
  output logic        [15:0]  clip_cnt_o
`endif
);

  localparam int         CNT_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic                    av;
  logic                    al;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] sum;
  logic                    first_q;
  logic [CNT_W-1:0]        ch_cnt_q;
  logic                    close;
  sat_t                    sat_r;
  logic [0:0]              state_q, state_d;
  sample_t                 mix_q, mix_d;
  logic                    overrun_q, overrun_d;

  mpmix_tagdly #(.DEPTH(MP_LATENCY)) u_tagdly (
    .clk     (clk),
    .rst     (rst),
    .valid_i (ch_valid_i),
    .last_i  (ch_last_i),
    .valid_o (av),
    .last_o  (al)
  );

  assign sum   = (first_q ? '0 : acc_q) + {{(ACC_W-SAMPLE_W){mprod_i[SAMPLE_W-1]}}, mprod_i};
  assign close = av & (al | (ch_cnt_q == CNT_W'(NUM_CH-1)));
  assign sat_r = sat24(32'(sum));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      first_q  <= 1'b1;
      ch_cnt_q <= '0;
    end else if (av) begin
      acc_q <= sum;
      if (close) begin
        first_q  <= 1'b1;
        ch_cnt_q <= '0;
      end else begin
        first_q  <= 1'b0;
        ch_cnt_q <= ch_cnt_q + 1'b1;
      end
    end
  end

  // A close always wins over a plain ack; ack in the close cycle only suppresses overrun.
  always_comb begin
    state_d   = state_q;
    mix_d     = mix_q;
    overrun_d = overrun_q;
    if (close) begin
      mix_d   = sat_r.value;
      state_d = ST_FULL;
      if ((state_q == ST_FULL) && !mix_ack_i) begin
        overrun_d = 1'b1;
      end
    end else if ((state_q == ST_FULL) && mix_ack_i) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      mix_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mix_q     <= mix_d;
      overrun_q <= overrun_d;
    end
  end

  assign mix_o       = mix_q;
  assign mix_valid_o = (state_q == ST_FULL);
  assign overrun_o   = overrun_q;

`ifdef MPMIX_CLIP_CNT_EN
  logic [15:0] clip_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      clip_cnt_q <= '0;
    end else if (close && sat_r.clipped && (clip_cnt_q != 16'hFFFF)) begin
      clip_cnt_q <= clip_cnt_q + 16'd1;
    end
  end

  assign clip_cnt_o = clip_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mpmix_accum.sv
// ============================================================================
// tb_mpmix_accum -- directed self-checking bench for mpmix_accum
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mpmix_accum;

  localparam int LAT = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ch_valid_i = 1'b0;
  logic               ch_last_i = 1'b0;
  logic signed [23:0] mprod_i;
  logic signed [23:0] mix_o;
  logic               mix_valid_o;
  logic               mix_ack_i = 1'b0;
  logic               overrun_o;
`ifdef MPMIX_CLIP_CNT_EN
  logic [15:0]        clip_cnt_o;
`endif

  logic signed [23:0] prod_in = '0;
  logic signed [23:0] pipe [LAT];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Stand-in for the multiplier: operands presented with a beat emerge LAT edges later.
  always @(posedge clk) begin
    pipe[0] <= prod_in;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mprod_i = pipe[LAT-1];

  mpmix_accum #(.NUM_CH(4), .MP_LATENCY(LAT), .ACC_W(28)) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_valid_i  (ch_valid_i),
    .ch_last_i   (ch_last_i),
    .mprod_i     (mprod_i),
    .mix_o       (mix_o),
    .mix_valid_o (mix_valid_o),
    .mix_ack_i   (mix_ack_i),
    .overrun_o   (overrun_o)
`ifdef MPMIX_CLIP_CNT_EN
    ,
    .clip_cnt_o  (clip_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic signed [23:0] p, input logic last);
    ch_valid_i = 1'b1;
    ch_last_i  = last;
    prod_in    = p;
    tick(1);
    ch_valid_i = 1'b0;
    ch_last_i  = 1'b0;
    prod_in    = '0;
  endtask

  task automatic ack();
    mix_ack_i = 1'b1;
    tick(1);
    mix_ack_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!mix_valid_o && n < 30) begin
      tick(1);
      n++;
    end
    check(tag, {23'd0, mix_valid_o}, 24'd1);
  endtask

  initial begin
    do_reset();
    check("rst_mix", mix_o, 24'd0);
    check("rst_valid", {23'd0, mix_valid_o}, 24'd0);
    check("rst_overrun", {23'd0, overrun_o}, 24'd0);
`ifdef MPMIX_CLIP_CNT_EN
    check("rst_clip", {8'd0, clip_cnt_o}, 24'd0);
`endif

    // 1: basic frame and latency (valid rises 6 cycles after last beat)
    beat(24'sd1000, 1'b0);
    beat(24'sd2000, 1'b0);
    beat(-24'sd500, 1'b0);
    beat(24'sd7, 1'b1);
    tick(4);
    check("t1_not_yet", {23'd0, mix_valid_o}, 24'd0);
    tick(1);
    check("t1_valid", {23'd0, mix_valid_o}, 24'd1);
    check("t1_mix", mix_o, 24'd2507);
    ack();
    check("t1_acked", {23'd0, mix_valid_o}, 24'd0);
    ack();
    check("t1_ack_empty", {23'd0, mix_valid_o}, 24'd0);

    // 2: positive and negative saturation
    repeat (4) beat(24'h7FFFFF, 1'b0);
    wait_valid("t2a_wait");
    check("t2a_mix", mix_o, 24'h7FFFFF);
`ifdef MPMIX_CLIP_CNT_EN
    check("t2a_clip", {8'd0, clip_cnt_o}, 24'd1);
`endif
    ack();
    repeat (3) beat(24'h800000, 1'b0);
    beat(24'h800000, 1'b1);
    wait_valid("t2b_wait");
    check("t2b_mix", mix_o, 24'h800000);
`ifdef MPMIX_CLIP_CNT_EN
    check("t2b_clip", {8'd0, clip_cnt_o}, 24'd2);
`endif
    ack();

    // 3: overrun without ack, then ack in the close cycle
    beat(24'sd1, 1'b0); beat(24'sd2, 1'b0); beat(24'sd3, 1'b0); beat(24'sd4, 1'b1);
    wait_valid("t3a_wait1");
    check("t3a_mix1", mix_o, 24'd10);
    beat(24'sd10, 1'b0); beat(24'sd20, 1'b1);
    tick(LAT + 1);
    check("t3a_overrun", {23'd0, overrun_o}, 24'd1);
    check("t3a_mix2", mix_o, 24'd30);
    do_reset();
    beat(24'sd1, 1'b0); beat(24'sd2, 1'b0); beat(24'sd3, 1'b0); beat(24'sd4, 1'b1);
    wait_valid("t3b_wait1");
    beat(24'sd10, 1'b0); beat(24'sd20, 1'b1);
    tick(LAT - 1);
    mix_ack_i = 1'b1;
    tick(1);
    mix_ack_i = 1'b0;
    check("t3b_valid", {23'd0, mix_valid_o}, 24'd1);
    check("t3b_mix2", mix_o, 24'd30);
    check("t3b_no_overrun", {23'd0, overrun_o}, 24'd0);
    ack();

    // 4: NUM_CH-th beat closes without last; 2-beat frame
    beat(24'sd1, 1'b0); beat(24'sd2, 1'b0); beat(24'sd3, 1'b0); beat(24'sd4, 1'b0);
    beat(24'sd100, 1'b0); beat(24'sd5, 1'b1);
    wait_valid("t4a_wait");
    check("t4a_mix", mix_o, 24'd10);
    ack();
    wait_valid("t4b_wait");
    check("t4b_mix", mix_o, 24'd105);
    check("t4b_no_overrun", {23'd0, overrun_o}, 24'd0);
    ack();
    beat(24'sd7, 1'b0); beat(24'sd8, 1'b1);
    wait_valid("t4c_wait");
    check("t4c_mix", mix_o, 24'd15);
    ack();

    // 5: gapped beats
    beat(24'sd100, 1'b0); tick(3);
    beat(24'sd200, 1'b0); tick(3);
    beat(24'sd300, 1'b1);
    wait_valid("t5_wait");
    check("t5_mix", mix_o, 24'd600);
    ack();

    // 6: reset mid-frame discards partial sum and in-flight tags
    beat(24'sd50, 1'b0); beat(24'sd60, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_rst_mix", mix_o, 24'd0);
    check("t6_rst_valid", {23'd0, mix_valid_o}, 24'd0);
    tick(8);
    check("t6_still_empty", {23'd0, mix_valid_o}, 24'd0);
    beat(24'sd5, 1'b0); beat(24'sd6, 1'b1);
    wait_valid("t6_wait");
    check("t6_mix", mix_o, 24'd11);
    check("t6_overrun", {23'd0, overrun_o}, 24'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
